// File: rtl/itch_pkg.sv
// Shared definitions for the ITCH message assembler: byte width, message type codes,
// FSM state encoding and the keep popcount helper.
package itch_pkg;

   localparam int ITCH_LEN        = 8;
   localparam int ITCH_AXI_KEEP_W = 8;
   localparam int KEEP_MAX_W      = 64;

   // Message type codes carried in byte 0 of every ITCH message
   localparam logic [ITCH_LEN-1:0] MSG_SYSTEM_EVENT = 8'h53;
   localparam logic [ITCH_LEN-1:0] MSG_ADD_ORDER    = 8'h41;
   localparam logic [ITCH_LEN-1:0] MSG_EXECUTED     = 8'h45;
   localparam logic [ITCH_LEN-1:0] MSG_DELETE       = 8'h44;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DISCARD
   } state_e;

   function automatic int keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
      int n;
      n = 0;
      for (int i = 0; i < KEEP_MAX_W; i++) begin
         n += int'(keep[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/itch_beat_pack.sv
// One payload beat: zeroes bytes whose keep bit is clear and counts the valid bytes.
module itch_beat_pack
   import itch_pkg::*;
#(
   parameter int AXI_DATA_W = 64,
   parameter int AXI_KEEP_W = AXI_DATA_W / 8,
   parameter int LEN        = ITCH_LEN,
   parameter int PCNT_W     = $clog2(AXI_KEEP_W + 1)
) (
   input  logic [AXI_KEEP_W-1:0] keep_i,
   input  logic [AXI_DATA_W-1:0] data_i,
   output logic [AXI_DATA_W-1:0] data_o,
   output logic [PCNT_W-1:0]     pop_o
);

   always_comb begin
      data_o = '0;
      for (int k = 0; k < AXI_KEEP_W; k++) begin
         if (keep_i[k]) begin
            data_o[LEN*k +: LEN] = data_i[LEN*k +: LEN];
         end
      end
   end

   assign pop_o = PCNT_W'(keep_popcount(KEEP_MAX_W'(keep_i)));

endmodule

// File: rtl/itch_msg_assembler.sv
// Assembles MoldUDP64 payload beats into whole ITCH messages and hands them out
// through a single-entry hold register on a valid/ready port.
module itch_msg_assembler
   import itch_pkg::*;
#(
   parameter int AXI_DATA_W    = 64,
   parameter int AXI_KEEP_W    = AXI_DATA_W / 8,
   parameter int LEN           = ITCH_LEN,
   parameter int MSG_MAX_BYTES = 50,
   parameter int CNT_MAX       = (MSG_MAX_BYTES + AXI_KEEP_W - 1) / AXI_KEEP_W,
   parameter int CNT_W         = $clog2(CNT_MAX + 1),
   parameter int MAX_W         = CNT_MAX * AXI_DATA_W,
   parameter int LEN_W         = $clog2(MSG_MAX_BYTES + 1),
   parameter int DROP_CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  mold_v_i,
   input  logic                  mold_start_i,
   input  logic                  mold_last_i,
   input  logic [AXI_KEEP_W-1:0] mold_keep_i,
   input  logic [AXI_DATA_W-1:0] mold_data_i,
   output logic                  itch_v_o,
   input  logic                  itch_ready_i,
   output logic [MAX_W-1:0]      itch_data_o,
   output logic [LEN_W-1:0]      itch_len_o,
   output logic [LEN-1:0]        itch_type_o,
   output logic                  ovf_o,
   output logic                  abort_o,
   output logic                  drop_o,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
);

   localparam int PCNT_W = $clog2(AXI_KEEP_W + 1);
   localparam int SUM_W  = LEN_W + 1;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [AXI_DATA_W-1:0]   acc_q [CNT_MAX];
   logic [AXI_DATA_W-1:0]   msg_cur [CNT_MAX];
   logic [CNT_MAX-1:0]      slot_we;
   logic                    clr_rest;
   logic [AXI_DATA_W-1:0]   beat_data;
   logic [PCNT_W-1:0]       beat_pop;
   logic [SUM_W-1:0]        len_sum;
   logic                    complete;
   logic                    hold_free;
   logic                    itch_v_q, itch_v_d;
   logic [MAX_W-1:0]        hold_data_q, hold_data_d;
   logic [LEN_W-1:0]        hold_len_q, hold_len_d;
   logic                    ovf_q, ovf_d;
   logic                    abort_q, abort_d;
   logic                    drop_q, drop_d;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   itch_beat_pack #(
      .AXI_DATA_W (AXI_DATA_W),
      .AXI_KEEP_W (AXI_KEEP_W),
      .LEN        (LEN),
      .PCNT_W     (PCNT_W)
   ) u_beat_pack (
      .keep_i (mold_keep_i),
      .data_i (mold_data_i),
      .data_o (beat_data),
      .pop_o  (beat_pop)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      slot_we  = '0;
      clr_rest = 1'b0;
      complete = 1'b0;
      ovf_d    = 1'b0;
      abort_d  = 1'b0;
      len_sum  = ((mold_start_i) ? '0 : SUM_W'(len_q)) + SUM_W'(beat_pop);

      if (mold_v_i && mold_start_i) begin
         // A start always restarts the accumulator, whatever was in progress
         abort_d    = (state_q != IDLE);
         slot_we[0] = 1'b1;
         clr_rest   = 1'b1;
         cnt_d      = CNT_W'(1);
         len_d      = LEN_W'(len_sum);
         state_d    = ACC;
         if (mold_last_i) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            len_d    = '0;
         end
      end else if (mold_v_i) begin
         case (state_q)
            ACC: begin
               if (cnt_q == CNT_W'(CNT_MAX) || len_sum > SUM_W'(MSG_MAX_BYTES)) begin
                  ovf_d   = 1'b1;
                  state_d = mold_last_i ? IDLE : DISCARD;
                  cnt_d   = '0;
                  len_d   = '0;
               end else begin
                  slot_we[cnt_q] = 1'b1;
                  cnt_d          = cnt_q + CNT_W'(1);
                  len_d          = LEN_W'(len_sum);
                  if (mold_last_i) begin
                     complete = 1'b1;
                     state_d  = IDLE;
                     cnt_d    = '0;
                     len_d    = '0;
                  end
               end
            end
            DISCARD: begin
               if (mold_last_i) begin
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end

      for (int i = 0; i < CNT_MAX; i++) begin
         if (slot_we[i]) begin
            msg_cur[i] = beat_data;
         end else if (clr_rest) begin
            msg_cur[i] = '0;
         end else begin
            msg_cur[i] = acc_q[i];
         end
      end
   end

   // Hold register accepts a new message when empty or emptying this cycle
   always_comb begin
      hold_free   = ~itch_v_q | itch_ready_i;
      itch_v_d    = itch_v_q & ~itch_ready_i;
      hold_data_d = hold_data_q;
      hold_len_d  = hold_len_q;
      drop_d      = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      if (complete) begin
         if (hold_free) begin
            itch_v_d   = 1'b1;
            hold_len_d = LEN_W'(len_sum);
            for (int i = 0; i < CNT_MAX; i++) begin
               hold_data_d[i*AXI_DATA_W +: AXI_DATA_W] = msg_cur[i];
            end
         end else begin
            drop_d = 1'b1;
            if (drop_cnt_q != '1) begin
               drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         itch_v_q    <= 1'b0;
         hold_data_q <= '0;
         hold_len_q  <= '0;
         ovf_q       <= 1'b0;
         abort_q     <= 1'b0;
         drop_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         itch_v_q    <= itch_v_d;
         hold_data_q <= hold_data_d;
         hold_len_q  <= hold_len_d;
         ovf_q       <= ovf_d;
         abort_q     <= abort_d;
         drop_q      <= drop_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CNT_MAX; i++) begin
         acc_q[i] <= msg_cur[i];
      end
   end

   assign itch_v_o    = itch_v_q;
   assign itch_data_o = hold_data_q;
   assign itch_len_o  = hold_len_q;
   assign itch_type_o = hold_data_q[LEN-1:0];
   assign ovf_o       = ovf_q;
   assign abort_o     = abort_q;
   assign drop_o      = drop_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Scoreboard bench for itch_msg_assembler: expected messages are queued as they are
// sent and compared while the DUT presents them.
module tb_itch_msg_assembler;

   localparam int DW      = 64;
   localparam int KW      = 8;
   localparam int MSG_MAX = 50;
   localparam int CMAX    = 7;
   localparam int MW      = CMAX * DW;
   localparam int LW      = 6;
   localparam int DCW     = 16;

   typedef struct {
      int            len;
      logic [MW-1:0] data;
   } msg_t;

   logic           clk = 1'b0;
   logic           nreset = 1'b0;
   logic           mold_v_i = 1'b0;
   logic           mold_start_i = 1'b0;
   logic           mold_last_i = 1'b0;
   logic [KW-1:0]  mold_keep_i = '0;
   logic [DW-1:0]  mold_data_i = '0;
   logic           itch_v_o;
   logic           itch_ready_i = 1'b1;
   logic [MW-1:0]  itch_data_o;
   logic [LW-1:0]  itch_len_o;
   logic [7:0]     itch_type_o;
   logic           ovf_o;
   logic           abort_o;
   logic           drop_o;
   logic [DCW-1:0] drop_cnt_o;

   msg_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_deliv = 0;
   int   n_ovf = 0;
   int   n_abort = 0;
   int   n_drop = 0;
   int   ovf_cyc = 0;

   itch_msg_assembler dut (
      .clk          (clk),
      .nreset       (nreset),
      .mold_v_i     (mold_v_i),
      .mold_start_i (mold_start_i),
      .mold_last_i  (mold_last_i),
      .mold_keep_i  (mold_keep_i),
      .mold_data_i  (mold_data_i),
      .itch_v_o     (itch_v_o),
      .itch_ready_i (itch_ready_i),
      .itch_data_o  (itch_data_o),
      .itch_len_o   (itch_len_o),
      .itch_type_o  (itch_type_o),
      .ovf_o        (ovf_o),
      .abort_o      (abort_o),
      .drop_o       (drop_o),
      .drop_cnt_o   (drop_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [MW-1:0] mk_msg(input int n, input logic [7:0] base);
      logic [MW-1:0] d;
      d = '0;
      for (int b = 0; b < n && b < MW/8; b++) begin
         d[8*b +: 8] = 8'(base + b);
      end
      return d;
   endfunction

   task automatic drive_beat(input bit v, input bit s, input bit l,
                             input logic [KW-1:0] k, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      mold_v_i     = v;
      mold_start_i = s;
      mold_last_i  = l;
      mold_keep_i  = k;
      mold_data_i  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         mold_v_i     = 1'b0;
         mold_start_i = 1'b0;
         mold_last_i  = 1'b0;
      end
   endtask

   task automatic send_msg(input int n, input logic [7:0] base, input bit do_last,
                           output msg_t m, output int first_cyc);
      int nb;
      nb        = (n + KW - 1) / KW;
      m.len     = n;
      m.data    = mk_msg(n, base);
      first_cyc = 0;
      for (int j = 0; j < nb; j++) begin
         logic [KW-1:0] k;
         logic [DW-1:0] d;
         for (int b = 0; b < KW; b++) begin
            int idx;
            idx          = j * KW + b;
            k[b]         = (idx < n);
            d[8*b +: 8]  = (idx < n) ? 8'(base + idx) : 8'hEE;
         end
         drive_beat(1'b1, j == 0, do_last && (j == nb - 1), k, d);
         if (j == 0) first_cyc = cyc;
      end
   endtask

   always @(negedge clk) begin
      if (nreset) begin
         if (itch_v_o) begin
            if (sb.size() == 0) begin
               check("unexpected_msg", 512'(itch_v_o), 512'(0));
            end else begin
               check("msg_len", 512'(itch_len_o), 512'(sb[0].len));
               check("msg_type", 512'(itch_type_o), 512'(sb[0].data[7:0]));
               check("msg_data", 512'(itch_data_o), 512'(sb[0].data));
               if (itch_ready_i) begin
                  void'(sb.pop_front());
                  n_deliv++;
               end
            end
         end
         if (ovf_o) begin
            n_ovf++;
            ovf_cyc = cyc;
         end
         if (abort_o) n_abort++;
         if (drop_o) n_drop++;
      end
   end

   initial begin
      msg_t m;
      msg_t m2;
      int   fc;
      int   d0;
      int   e0;
      int   exp_idx;
      int   ln;

      #23;
      check("rst_v", 512'(itch_v_o), 512'(0));
      check("rst_len", 512'(itch_len_o), 512'(0));
      check("rst_type", 512'(itch_type_o), 512'(0));
      check("rst_data", 512'(itch_data_o), 512'(0));
      check("rst_ovf", 512'(ovf_o), 512'(0));
      check("rst_abort", 512'(abort_o), 512'(0));
      check("rst_drop", 512'(drop_o), 512'(0));
      check("rst_dropcnt", 512'(drop_cnt_o), 512'(0));
      @(negedge clk);
      nreset = 1'b1;
      idle(2);

      // single-beat message, latency 1
      send_msg(6, 8'h41, 1'b1, m, fc);
      sb.push_back(m);
      idle(1);
      @(negedge clk);
      check("t1_v", 512'(itch_v_o), 512'(1));
      check("t1_len", 512'(itch_len_o), 512'(6));
      check("t1_type", 512'(itch_type_o), 512'(8'h41));
      check("t1_upper", 512'(itch_data_o[MW-1:48]), 512'(0));
      idle(3);

      // 36-byte add order
      d0 = n_deliv;
      send_msg(36, 8'h41, 1'b1, m, fc);
      sb.push_back(m);
      idle(4);
      check("t2_deliv", 512'(n_deliv - d0), 512'(1));

      // overflow on 8 full beats
      exp_idx = -1;
      ln      = 0;
      for (int j = 0; j < 8; j++) begin
         if (j == 0) ln = KW;
         else if (exp_idx < 0) begin
            if (j == CMAX || ln + KW > MSG_MAX) exp_idx = j;
            else ln += KW;
         end
      end
      d0 = n_deliv;
      e0 = n_ovf;
      send_msg(64, 8'h10, 1'b1, m, fc);
      idle(4);
      check("t3_ovf_cnt", 512'(n_ovf - e0), 512'(1));
      check("t3_ovf_beat", 512'(ovf_cyc - fc), 512'(exp_idx + 1));
      check("t3_no_deliv", 512'(n_deliv - d0), 512'(0));
      send_msg(20, 8'h53, 1'b1, m, fc);
      sb.push_back(m);
      idle(4);
      check("t3_after", 512'(n_deliv - d0), 512'(1));

      // abort: partial message replaced by a new start
      d0 = n_deliv;
      e0 = n_abort;
      send_msg(24, 8'h30, 1'b0, m, fc);
      send_msg(37, 8'h45, 1'b1, m2, fc);
      sb.push_back(m2);
      idle(4);
      check("t4_abort", 512'(n_abort - e0), 512'(1));
      check("t4_deliv", 512'(n_deliv - d0), 512'(1));

      // backpressure, drop, then same-cycle accept and load
      d0 = n_deliv;
      e0 = n_drop;
      itch_ready_i = 1'b0;
      send_msg(16, 8'h44, 1'b1, m, fc);
      sb.push_back(m);
      send_msg(12, 8'h50, 1'b1, m2, fc);
      idle(5);
      check("t5_drop", 512'(n_drop - e0), 512'(1));
      check("t5_dropcnt", 512'(drop_cnt_o), 512'(1));
      check("t5_held_v", 512'(itch_v_o), 512'(1));
      check("t5_held_len", 512'(itch_len_o), 512'(16));
      send_msg(10, 8'h58, 1'b1, m2, fc);
      itch_ready_i = 1'b1;
      sb.push_back(m2);
      @(negedge clk);
      @(negedge clk);
      check("t5_v_stays", 512'(itch_v_o), 512'(1));
      check("t5_new_len", 512'(itch_len_o), 512'(10));
      idle(3);
      check("t5_deliv", 512'(n_deliv - d0), 512'(2));
      check("t5_v_low", 512'(itch_v_o), 512'(0));

      // asynchronous reset mid-message
      send_msg(24, 8'h60, 1'b0, m, fc);
      @(posedge clk);
      #3;
      mold_v_i = 1'b0;
      nreset   = 1'b0;
      #1;
      check("t6_v", 512'(itch_v_o), 512'(0));
      check("t6_len", 512'(itch_len_o), 512'(0));
      check("t6_data", 512'(itch_data_o), 512'(0));
      check("t6_dropcnt", 512'(drop_cnt_o), 512'(0));
      idle(2);
      @(negedge clk);
      nreset = 1'b1;
      idle(1);
      d0 = n_deliv;
      send_msg(8, 8'h41, 1'b1, m, fc);
      sb.push_back(m);
      idle(4);
      check("t6_deliv", 512'(n_deliv - d0), 512'(1));
      check("sb_empty", 512'(sb.size()), 512'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
